alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational 32-bit ALU between two requesters (port 0, port 1) with round-robin arbitration, a valid/ready request handshake and registered, tagged-by-port responses. It registers the ALU operands, holds them stable for a configurable multi-cycle window on multiply (the combinational multiplier is a multi-cycle path), and rejects control codes the ALU does not define. It sits between the requesting units and the ALU instance, and owns all ALU input drive.

## Interface

- MUL_LAT, 2: cycles the operands are held for ctrl 3'b001 (mul); legal range 1..15.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  port 0 request valid.
- req0_ready_o  output  1  port 0 request accepted this cycle when high with valid.
- req0_ctrl_i  input  3  port 0 ALU control code.
- req0_data1_i, req0_data2_i  input  32 each  port 0 operands.
- req1_valid_i, req1_ready_o, req1_ctrl_i, req1_data1_i, req1_data2_i: same as port 0, for port 1.
- rsp0_valid_o  output  1  one-cycle pulse: port 0 result valid.
- rsp0_data_o  output  32  port 0 result; holds until the next port 0 response.
- rsp0_err_o  output  1  port 0 result is for an illegal ctrl code; qualified by rsp0_valid_o.
- rsp1_valid_o, rsp1_data_o, rsp1_err_o: same as port 0, for port 1.
- alu_data1_o, alu_data2_o  output  32 each  registered operands to the ALU.
- alu_ctrl_o  output  3  registered control code to the ALU.
- alu_data_i  input  32  ALU result.
- busy_o  output  1  high while an operation is in EXEC.

## Operation

- Legal ctrl codes: 000 add, 001 mul, 010 sub, 011 and, 100 or. Codes 101–111 are illegal.
- FSM states:
  - IDLE: Arbitration is active. On accept, go to EXEC.
  - EXEC: Decrement cnt each cycle. When cnt==0, capture the result and go to IDLE.
- Arbitration, evaluated combinationally in IDLE:
  - Both valid: select the port that is not last_grant.
  - Only one valid: select that port.
  - Neither valid: select port 0.
- reqN_ready_o = (state==IDLE) && (sel==N). It is never high for both ports, and it is always low in EXEC.
- Accept = valid && ready. On accept:
  - Set last_grant to the accepted port and record the owner port.
  - Legal code: load alu_data1_o, alu_data2_o and alu_ctrl_o; set cnt = MUL_LAT-1 for mul, otherwise 0; clear the err flag.
  - Illegal code: leave the ALU operand registers unchanged; set cnt=0 and the err flag.
- EXEC exit, at the edge where cnt==0, for the owner port:
  - rspN_data_o takes alu_data_i, or 32'h0 if err.
  - rspN_err_o takes err.
  - rspN_valid_o goes high for exactly one cycle.
- There is no response backpressure; the requester must sink the pulse.
- The ALU operand registers hold their values between operations.
- Arithmetic is the ALU's own: 32-bit wrap-around for add and sub; mul keeps the low 32 bits of the product.

## Timing

- Reset (rst_i low, asynchronous):
  - State goes to IDLE, cnt=0, last_grant=1, so port 0 wins the first contention.
  - All rsp*_valid_o, rsp*_err_o and busy_o are 0.
  - All rsp*_data_o and alu_data*_o are 32'h0; alu_ctrl_o is 3'b000.
- Reset mid-EXEC drops the operation with no response. Release is synchronous to the next clk_i edge.
- Latency, with the accept edge at T:
  - Non-mul and illegal ops: rsp_valid is high in the cycle after edge T+1.
  - Mul: rsp_valid is high after edge T+MUL_LAT.
- Throughput: one non-mul op per 2 cycles. In the cycle rsp_valid is high, the state is already IDLE and a new accept may occur.
- alu_*_o are stable for the entire EXEC, i.e. MUL_LAT cycles for mul.
- busy_o is high for the EXEC cycles only.
- A request held valid without ready must keep its ctrl and operands stable; it is sampled only on the accept edge.
- Simultaneous events:
  - A response to port 0 and a new accept from port 0 in the same cycle are legal.
  - rsp0 and rsp1 never pulse in the same cycle.

## Test plan

- Reset, then port 0 requests add 5+7 -> req0_ready_o=1 immediately; rsp0_valid_o pulses 2 cycles after accept with data 12, err 0; busy_o high for 1 cycle.
- Both ports valid continuously: port 0 sub 10-3, port 1 and F0&3C -> grants alternate 0,1,0,1; responses 7 and 0x30 alternate every 2 cycles; neither port starves.
- MUL_LAT=3, port 1 mul 0x10000×0x10000 -> alu operands held 3 cycles; rsp1_data_o=0 (low 32 bits); ready low for both ports throughout EXEC.
- Port 0 ctrl 3'b110 -> accepted; rsp0_err_o=1, rsp0_data_o=0; alu_data*_o unchanged from the previous op.
- Assert rst_i low in the second cycle of a mul -> no rsp pulse; all outputs return to reset values; next contention is won by port 0.
- Add 0xFFFFFFFF+1, sub 0-1, or 0xA0|0x05 -> results 0, 0xFFFFFFFF, 0xA5.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU drive bundle for alu_arbiter
interface alu_arbiter_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [2:0]  req0_ctrl_i;
    logic [31:0] req0_data1_i;
    logic [31:0] req0_data2_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [2:0]  req1_ctrl_i;
    logic [31:0] req1_data1_i;
    logic [31:0] req1_data2_i;
    logic        rsp0_valid_o;
    logic [31:0] rsp0_data_o;
    logic        rsp0_err_o;
    logic        rsp1_valid_o;
    logic [31:0] rsp1_data_o;
    logic        rsp1_err_o;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        busy_o;

    modport slave (
        input  req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i,
        input  req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i,
        input  alu_data_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_data_o, rsp0_err_o,
        output rsp1_valid_o, rsp1_data_o, rsp1_err_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o
    );

    modport master (
        output req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i,
        output req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i,
        output alu_data_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_data_o, rsp0_err_o,
        input  rsp1_valid_o, rsp1_data_o, rsp1_err_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter owning a shared combinational ALU
module alu_arbiter #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus
);
    localparam logic [2:0] CTRL_MUL  = 3'b001;
    localparam logic [2:0] CTRL_LAST = 3'b100;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        owner;
    logic        err;
    logic        sel;
    logic        acc_valid;
    logic        acc_legal;
    logic [2:0]  acc_ctrl;
    logic [31:0] acc_data1;
    logic [31:0] acc_data2;

    // Contention goes to the port that did not win last time; otherwise the lone requester.
    always_comb begin
        sel = 1'b0;
        if (bus.req0_valid_i && bus.req1_valid_i)
            sel = ~last_grant;
        else if (bus.req1_valid_i)
            sel = 1'b1;
    end

    assign bus.req0_ready_o = (state == IDLE) && !sel;
    assign bus.req1_ready_o = (state == IDLE) && sel;
    assign bus.busy_o       = (state == EXEC);

    assign acc_valid = sel ? (bus.req1_valid_i && bus.req1_ready_o)
                           : (bus.req0_valid_i && bus.req0_ready_o);
    assign acc_ctrl  = sel ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
    assign acc_data1 = sel ? bus.req1_data1_i : bus.req0_data1_i;
    assign acc_data2 = sel ? bus.req1_data2_i : bus.req0_data2_i;
    assign acc_legal = (acc_ctrl <= CTRL_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            err              <= 1'b0;
            bus.alu_data1_o  <= 32'h0;
            bus.alu_data2_o  <= 32'h0;
            bus.alu_ctrl_o   <= 3'b000;
            bus.rsp0_valid_o <= 1'b0;
            bus.rsp0_data_o  <= 32'h0;
            bus.rsp0_err_o   <= 1'b0;
            bus.rsp1_valid_o <= 1'b0;
            bus.rsp1_data_o  <= 32'h0;
            bus.rsp1_err_o   <= 1'b0;
        end else begin
            bus.rsp0_valid_o <= 1'b0;
            bus.rsp1_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_valid) begin
                        state      <= EXEC;
                        last_grant <= sel;
                        owner      <= sel;
                        if (acc_legal) begin
                            bus.alu_data1_o <= acc_data1;
                            bus.alu_data2_o <= acc_data2;
                            bus.alu_ctrl_o  <= acc_ctrl;
                            cnt <= (acc_ctrl == CTRL_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
                            err <= 1'b0;
                        end else begin
                            // Operand registers keep the previous op so the ALU sees no glitch.
                            cnt <= 4'd0;
                            err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                        if (owner) begin
                            bus.rsp1_valid_o <= 1'b1;
                            bus.rsp1_data_o  <= err ? 32'h0 : bus.alu_data_i;
                            bus.rsp1_err_o   <= err;
                        end else begin
                            bus.rsp0_valid_o <= 1'b1;
                            bus.rsp0_data_o  <= err ? 32'h0 : bus.alu_data_i;
                            bus.rsp0_err_o   <= err;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized bench for alu_arbiter against a cycle-count reference model
module tb_alu_arbiter;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return p[31:0];
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return 32'h0;
        endcase
    endfunction

    assign bus.alu_data_i = alu_fn(bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o);

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Pending request per port, held stable until accepted
    logic        pend [2];
    logic [2:0]  op_c [2];
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        rnd_en = 1'b0;

    // Reference model: arbiter is free from cycle free_at; one response outstanding at most
    int          free_at;
    logic        lg;
    logic        have_rsp;
    logic        rsp_port;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] exp_a, exp_b;
    logic [2:0]  exp_c;
    logic [31:0] exp_rd [2];

    task automatic model_reset();
        free_at = 0; lg = 1'b1; have_rsp = 1'b0;
        exp_a = '0; exp_b = '0; exp_c = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
    endtask

    task automatic queue_op(input int p, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        pend[p] = 1'b1; op_c[p] = c; op_a[p] = a; op_b[p] = b;
    endtask

    task automatic drive();
        bus.req0_valid_i = pend[0]; bus.req0_ctrl_i = op_c[0];
        bus.req0_data1_i = op_a[0]; bus.req0_data2_i = op_b[0];
        bus.req1_valid_i = pend[1]; bus.req1_ctrl_i = op_c[1];
        bus.req1_data1_i = op_a[1]; bus.req1_data2_i = op_b[1];
    endtask

    task automatic step();
        logic exp_rv [2];
        logic idle;
        logic g;
        int   lat;
        @(negedge clk);
        cyc++;
        if (rnd_en)
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(1, 0) == 1)
                    queue_op(p, 3'($urandom_range(7, 0)),
                             ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom,
                             ($urandom_range(3, 0) == 0) ? 32'd1 : $urandom);
        drive();
        #1;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (have_rsp && cyc == free_at) begin
            exp_rv[rsp_port] = 1'b1;
            exp_rd[rsp_port] = rsp_data;
            have_rsp = 1'b0;
        end
        idle = (cyc >= free_at);
        check("busy", bus.busy_o, !idle);
        check("rsp0_valid", bus.rsp0_valid_o, exp_rv[0]);
        check("rsp1_valid", bus.rsp1_valid_o, exp_rv[1]);
        check("rsp0_data", bus.rsp0_data_o, exp_rd[0]);
        check("rsp1_data", bus.rsp1_data_o, exp_rd[1]);
        if (exp_rv[0]) check("rsp0_err", bus.rsp0_err_o, rsp_err);
        if (exp_rv[1]) check("rsp1_err", bus.rsp1_err_o, rsp_err);
        check("alu_data1", bus.alu_data1_o, exp_a);
        check("alu_data2", bus.alu_data2_o, exp_b);
        check("alu_ctrl", bus.alu_ctrl_o, exp_c);
        g = (pend[0] && pend[1]) ? !lg : pend[1];
        check("req0_ready", bus.req0_ready_o, idle && !g);
        check("req1_ready", bus.req1_ready_o, idle && g);
        if (idle && pend[g]) begin
            lat      = (op_c[g] == 3'd1) ? MUL_LAT : 1;
            lg       = g;
            free_at  = cyc + 1 + lat;
            have_rsp = 1'b1;
            rsp_port = g;
            rsp_err  = (op_c[g] > 3'd4);
            rsp_data = rsp_err ? 32'h0 : alu_fn(op_c[g], op_a[g], op_b[g]);
            if (!rsp_err) begin
                exp_a = op_a[g]; exp_b = op_b[g]; exp_c = op_c[g];
            end
            pend[g] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive();
        #1;
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_rsp0_valid", bus.rsp0_valid_o, 1'b0);
        check("rst_rsp1_valid", bus.rsp1_valid_o, 1'b0);
        check("rst_rsp0_err", bus.rsp0_err_o, 1'b0);
        check("rst_rsp1_err", bus.rsp1_err_o, 1'b0);
        check("rst_rsp0_data", bus.rsp0_data_o, 32'h0);
        check("rst_rsp1_data", bus.rsp1_data_o, 32'h0);
        check("rst_alu_data1", bus.alu_data1_o, 32'h0);
        check("rst_alu_data2", bus.alu_data2_o, 32'h0);
        check("rst_alu_ctrl", bus.alu_ctrl_o, 3'b000);
        check("rst_req0_ready", bus.req0_ready_o, 1'b1);
        check("rst_req1_ready", bus.req1_ready_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            op_c[p] = '0; op_a[p] = '0; op_b[p] = '0;
        end
        model_reset();
        drive();
        do_reset();

        queue_op(0, 3'd0, 32'd5, 32'd7);
        run(4);

        for (int i = 0; i < 12; i++) begin
            if (!pend[0]) queue_op(0, 3'd2, 32'd10, 32'd3);
            if (!pend[1]) queue_op(1, 3'd3, 32'hF0, 32'h3C);
            run(1);
        end
        run(4);

        queue_op(1, 3'd1, 32'h0001_0000, 32'h0001_0000);
        run(1);
        queue_op(0, 3'd0, 32'd1, 32'd2);
        run(8);

        queue_op(0, 3'b110, 32'h1234, 32'h5678);
        run(4);

        queue_op(0, 3'd1, 32'd3, 32'd4);
        run(2);
        do_reset();
        queue_op(0, 3'd4, 32'h1, 32'h2);
        queue_op(1, 3'd4, 32'h4, 32'h8);
        run(6);

        queue_op(0, 3'd0, 32'hFFFF_FFFF, 32'd1);
        run(3);
        queue_op(1, 3'd2, 32'd0, 32'd1);
        run(3);
        queue_op(0, 3'd4, 32'hA0, 32'h05);
        run(3);

        rnd_en = 1'b1;
        run(400);
        rnd_en = 1'b0;
        run(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
